// File: rtl/cpu_tb_pkg.sv
// cpu_tb_pkg
// Shared definitions for the result trace monitor: FSM state encoding,
// expected-trace entry width and the field slices inside one entry.
// An entry is {addr[31:0], Result[31:0]}, addr in the upper half.
package cpu_tb_pkg;

  localparam int ENTRY_W  = 64;
  localparam int ADDR_MSB = 63;
  localparam int ADDR_LSB = 32;
  localparam int RES_MSB  = 31;
  localparam int RES_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TMO  = 3'd4
  } state_e;

  // Packs one expected (addr, Result) pair into the ROM entry layout.
  function automatic logic [ENTRY_W-1:0] make_entry(input logic [31:0] a,
                                                     input logic [31:0] r);
    return {a, r};
  endfunction

endpackage

// File: rtl/expect_rom.sv
// expect_rom
// Combinational-read ROM holding the expected (addr, Result) trace.
// Contents come from INIT_IMAGE, entry i at INIT_IMAGE[i*64 +: 64].
// INIT_FILE names the trace image the contents correspond to.
// Ports:
//   idx_i  : entry index
//   data_o : entry {addr, Result}
module expect_rom
  import cpu_tb_pkg::*;
#(
  parameter int                          DEPTH      = 16,
  parameter string                       INIT_FILE  = "expect.hex",
  parameter logic [DEPTH*ENTRY_W-1:0]    INIT_IMAGE = '0,
  localparam int                         IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [IW-1:0]      idx_i,
  output logic [ENTRY_W-1:0] data_o
);

  // Sized to the full index range so any index value reads a defined word.
  localparam int SIZE = 1 << IW;

  logic [ENTRY_W-1:0] mem [SIZE];

  generate
    for (genvar i = 0; i < SIZE; i++) begin : g_word
      if (i < DEPTH) begin : g_used
        assign mem[i] = INIT_IMAGE[i*ENTRY_W +: ENTRY_W];
      end else begin : g_pad
        assign mem[i] = '0;
      end
    end
  endgenerate

  assign data_o = mem[idx_i];

endmodule

// File: rtl/result_trace_monitor.sv
// result_trace_monitor
// Watches the (addr, Result) pair coming out of a single-cycle computer and
// checks it against an expected trace held in expect_rom. Each time addr
// equals the next expected address the Result is compared; a mismatch is
// counted and the first one is captured. The run ends in PASS/FAIL once the
// whole trace has been seen, or in TMO when no expected address shows up
// within TIMEOUT cycles. Terminal states hold until Reset.
// Ports:
//   Clock, Reset   : clock, asynchronous active-high reset
//   Result, addr   : sampled result word and instruction address
//   done/pass/fail : terminal status (fail covers FAIL and TMO)
//   err_count      : value mismatches, saturating at 255
//   match_idx      : index of the next expected entry
//   cycle_count    : cycles spent in RUN, saturating at 65535
//   fail_addr/fail_result : pair captured at the first mismatch
//   dbg_state_o    : current FSM state
module result_trace_monitor
  import cpu_tb_pkg::*;
#(
  parameter int                       DEPTH      = 16,
  parameter int                       TIMEOUT    = 1024,
  parameter string                    INIT_FILE  = "expect.hex",
  parameter logic [DEPTH*ENTRY_W-1:0] INIT_IMAGE = '0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Result,
  input  logic [31:0] addr,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [7:0]  err_count,
  output logic [7:0]  match_idx,
  output logic [15:0] cycle_count,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_result,
  output state_e      dbg_state_o
);

  localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Index is one bit wider than the output so DEPTH=256 can be reached.
  localparam logic [8:0] DEPTH_IDX = 9'(DEPTH);
  localparam logic [31:0] TMO_LIM  = 32'(TIMEOUT);

  state_e             state_q;
  logic [8:0]         idx_q;
  logic [31:0]        tmo_q;
  logic [7:0]         err_q;
  logic [15:0]        cyc_q;
  logic [31:0]        fail_addr_q;
  logic [31:0]        fail_res_q;
  logic               done_q;
  logic               pass_q;
  logic               fail_q;

  logic [ENTRY_W-1:0] rom_word;

  expect_rom #(
    .DEPTH      (DEPTH),
    .INIT_FILE  (INIT_FILE),
    .INIT_IMAGE (INIT_IMAGE)
  ) u_rom (
    .idx_i  (idx_q[IW-1:0]),
    .data_o (rom_word)
  );

  // Candidate next values and compare results for the RUN state.
  logic        trace_end;
  logic        hit;
  logic        res_ok;
  logic [8:0]  idx_d;
  logic [7:0]  err_d;
  logic [15:0] cyc_d;
  logic [31:0] tmo_d;
  logic        tmo_expire;

  always_comb begin
    trace_end  = (idx_q == DEPTH_IDX);
    // An unknown address never counts as a hit; once the trace is complete
    // the ROM word is stale and must not be compared.
    hit        = !trace_end && !$isunknown(addr) &&
                 (addr == rom_word[ADDR_MSB:ADDR_LSB]);
    res_ok     = (Result == rom_word[RES_MSB:RES_LSB]);
    idx_d      = idx_q + 9'd1;
    err_d      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    cyc_d      = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
    tmo_d      = tmo_q + 32'd1;
    tmo_expire = (tmo_d >= TMO_LIM);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      err_q       <= '0;
      cyc_q       <= '0;
      fail_addr_q <= '0;
      fail_res_q  <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          cyc_q <= cyc_d;
          if (trace_end) begin
            done_q <= 1'b1;
            if (err_q == 8'd0) begin
              state_q <= S_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
            end
          end else if (hit) begin
            // A hit wins over a timeout expiring on the same edge.
            idx_q <= idx_d;
            tmo_q <= '0;
            if (!res_ok) begin
              err_q <= err_d;
              if (err_q == 8'd0) begin
                fail_addr_q <= addr;
                fail_res_q  <= Result;
              end
            end
          end else begin
            tmo_q <= tmo_d;
            if (tmo_expire) begin
              state_q <= S_TMO;
              done_q  <= 1'b1;
              fail_q  <= 1'b1;
            end
          end
        end
        default: begin
          // PASS, FAIL, TMO: everything frozen until Reset.
        end
      endcase
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign err_count   = err_q;
  assign match_idx   = idx_q[8] ? 8'hFF : idx_q[7:0];
  assign cycle_count = cyc_q;
  assign fail_addr   = fail_addr_q;
  assign fail_result = fail_res_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_result_trace_monitor.sv
// Directed bench for result_trace_monitor. Two instances share clock and
// inputs: u_a uses the default TIMEOUT, u_b uses TIMEOUT=8. Both load the
// 4-entry trace {(0,5),(4,7),(8,12),(C,0)} from a parameter image.
module tb_result_trace_monitor;
  import cpu_tb_pkg::*;

  localparam logic [4*ENTRY_W-1:0] IMG = {
    make_entry(32'hC, 32'd0),
    make_entry(32'h8, 32'd12),
    make_entry(32'h4, 32'd7),
    make_entry(32'h0, 32'd5)
  };
  localparam logic [31:0] IDLE_ADDR = 32'h100;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic [31:0] addr = IDLE_ADDR;
  logic [31:0] result = '0;

  logic        done_a, pass_a, fail_a;
  logic [7:0]  err_a, idx_a;
  logic [15:0] cyc_a;
  logic [31:0] fa_a, fr_a;
  state_e      st_a;

  logic        done_b, pass_b, fail_b;
  logic [7:0]  err_b, idx_b;
  logic [15:0] cyc_b;
  logic [31:0] fa_b, fr_b;
  state_e      st_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_trace_monitor #(
    .DEPTH(4), .TIMEOUT(1024), .INIT_FILE(""), .INIT_IMAGE(IMG)
  ) u_a (
    .Clock(clk), .Reset(rst_a), .Result(result), .addr(addr),
    .done(done_a), .pass(pass_a), .fail(fail_a), .err_count(err_a),
    .match_idx(idx_a), .cycle_count(cyc_a), .fail_addr(fa_a),
    .fail_result(fr_a), .dbg_state_o(st_a)
  );

  result_trace_monitor #(
    .DEPTH(4), .TIMEOUT(8), .INIT_FILE(""), .INIT_IMAGE(IMG)
  ) u_b (
    .Clock(clk), .Reset(rst_b), .Result(result), .addr(addr),
    .done(done_b), .pass(pass_b), .fail(fail_b), .err_count(err_b),
    .match_idx(idx_b), .cycle_count(cyc_b), .fail_addr(fa_b),
    .fail_result(fr_b), .dbg_state_o(st_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one (addr, Result) pair, let one edge sample it, settle 1 time unit.
  task automatic tick(input logic [31:0] a, input logic [31:0] r);
    addr   = a;
    result = r;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a  = 1'b1;
    addr   = IDLE_ADDR;
    result = '0;
    #1;
    chk("a_rst_done", 32'(done_a), 32'd0);
    chk("a_rst_pass", 32'(pass_a), 32'd0);
    chk("a_rst_fail", 32'(fail_a), 32'd0);
    chk("a_rst_err",  32'(err_a),  32'd0);
    chk("a_rst_idx",  32'(idx_a),  32'd0);
    chk("a_rst_cyc",  32'(cyc_a),  32'd0);
    chk("a_rst_faddr", fa_a, 32'd0);
    chk("a_rst_fres",  fr_a, 32'd0);
    chk("a_rst_state", 32'(st_a), 32'(S_IDLE));
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    tick(IDLE_ADDR, 32'd0);
    chk("a_run_state", 32'(st_a), 32'(S_RUN));
    chk("a_run_cyc",   32'(cyc_a), 32'd0);
  endtask

  task automatic reset_b();
    rst_b  = 1'b1;
    addr   = IDLE_ADDR;
    result = '0;
    #1;
    chk("b_rst_state", 32'(st_b), 32'(S_IDLE));
    chk("b_rst_fail",  32'(fail_b), 32'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    tick(IDLE_ADDR, 32'd0);
    chk("b_run_state", 32'(st_b), 32'(S_RUN));
  endtask

  initial begin
    // Clean trace -> PASS.
    reset_a();
    tick(32'h0, 32'd5);
    chk("t1_idx1", 32'(idx_a), 32'd1);
    chk("t1_cyc1", 32'(cyc_a), 32'd1);
    tick(32'h4, 32'd7);
    tick(32'h8, 32'd12);
    tick(32'hC, 32'd0);
    chk("t1_idx4",  32'(idx_a), 32'd4);
    chk("t1_done0", 32'(done_a), 32'd0);
    tick(IDLE_ADDR, 32'd0);
    chk("t1_pass",  32'(pass_a), 32'd1);
    chk("t1_done",  32'(done_a), 32'd1);
    chk("t1_fail",  32'(fail_a), 32'd0);
    chk("t1_err",   32'(err_a),  32'd0);
    chk("t1_idx",   32'(idx_a),  32'd4);
    chk("t1_cyc",   32'(cyc_a),  32'd5);
    chk("t1_state", 32'(st_a),   32'(S_PASS));
    tick(32'h0, 32'd5);
    tick(32'h4, 32'd9);
    chk("t1_frz_cyc", 32'(cyc_a), 32'd5);
    chk("t1_frz_idx", 32'(idx_a), 32'd4);
    chk("t1_frz_err", 32'(err_a), 32'd0);

    // Result 13 at addr 8 -> FAIL with capture.
    reset_a();
    tick(32'h0, 32'd5);
    tick(32'h4, 32'd7);
    tick(32'h8, 32'd13);
    chk("t2_err_now", 32'(err_a), 32'd1);
    chk("t2_faddr_now", fa_a, 32'h8);
    tick(32'hC, 32'd0);
    tick(IDLE_ADDR, 32'd0);
    chk("t2_fail",  32'(fail_a), 32'd1);
    chk("t2_pass",  32'(pass_a), 32'd0);
    chk("t2_done",  32'(done_a), 32'd1);
    chk("t2_err",   32'(err_a),  32'd1);
    chk("t2_faddr", fa_a, 32'h8);
    chk("t2_fres",  fr_a, 32'd13);
    chk("t2_state", 32'(st_a), 32'(S_FAIL));

    // Two mismatches: only the first is captured.
    reset_a();
    tick(32'h0, 32'd5);
    tick(32'h4, 32'd9);
    tick(32'h8, 32'd12);
    tick(32'hC, 32'd1);
    tick(IDLE_ADDR, 32'd0);
    chk("t4_err",   32'(err_a),  32'd2);
    chk("t4_faddr", fa_a, 32'h4);
    chk("t4_fres",  fr_a, 32'd9);
    chk("t4_fail",  32'(fail_a), 32'd1);
    chk("t4_idx",   32'(idx_a),  32'd4);

    // Miss cycles leave the index alone.
    reset_a();
    tick(32'h4, 32'd7);
    tick(32'h8, 32'd12);
    chk("t_miss_idx", 32'(idx_a), 32'd0);
    chk("t_miss_cyc", 32'(cyc_a), 32'd2);

    // Reset pulsed mid-trace, then full replay.
    reset_a();
    tick(32'h0, 32'd5);
    tick(32'h4, 32'd7);
    chk("t5_idx2", 32'(idx_a), 32'd2);
    rst_a = 1'b1;
    #1;
    chk("t5_async_idx",   32'(idx_a), 32'd0);
    chk("t5_async_state", 32'(st_a), 32'(S_IDLE));
    reset_a();
    chk("t5_restart_idx", 32'(idx_a), 32'd0);
    tick(32'h0, 32'd5);
    tick(32'h4, 32'd7);
    tick(32'h8, 32'd12);
    tick(32'hC, 32'd0);
    tick(IDLE_ADDR, 32'd0);
    chk("t5_pass", 32'(pass_a), 32'd1);
    chk("t5_err",  32'(err_a),  32'd0);

    // TIMEOUT=8 with addr parked off-trace.
    reset_b();
    repeat (7) tick(IDLE_ADDR, 32'd0);
    chk("t3_pre_fail",  32'(fail_b), 32'd0);
    chk("t3_pre_state", 32'(st_b), 32'(S_RUN));
    tick(IDLE_ADDR, 32'd0);
    chk("t3_fail",  32'(fail_b), 32'd1);
    chk("t3_pass",  32'(pass_b), 32'd0);
    chk("t3_done",  32'(done_b), 32'd1);
    chk("t3_cyc",   32'(cyc_b),  32'd8);
    chk("t3_state", 32'(st_b), 32'(S_TMO));
    tick(32'h0, 32'd5);
    chk("t3_frz_cyc", 32'(cyc_b), 32'd8);
    chk("t3_frz_idx", 32'(idx_b), 32'd0);

    // Hit on the edge the timeout would expire: hit wins, counter clears.
    reset_b();
    repeat (7) tick(IDLE_ADDR, 32'd0);
    tick(32'h0, 32'd5);
    chk("t6_idx",   32'(idx_b), 32'd1);
    chk("t6_state", 32'(st_b), 32'(S_RUN));
    chk("t6_fail",  32'(fail_b), 32'd0);
    repeat (7) tick(IDLE_ADDR, 32'd0);
    chk("t6_cleared_state", 32'(st_b), 32'(S_RUN));
    tick(IDLE_ADDR, 32'd0);
    chk("t6_tmo_state", 32'(st_b), 32'(S_TMO));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
